// File: rtl/bank_interleave_sequencer_pkg.sv
// Shared state, command and helper definitions for the bank interleave sequencer.
package bank_interleave_sequencer_pkg;

   typedef enum logic [3:0] {
      IDLE, ACT, ACT_GAP, RCD_WAIT, WRITE, READ, RD_GAP, PRE_WAIT, REFRESH, RFC_WAIT, DONE
   } state_e;

   typedef enum logic [2:0] { CMD_DES, CMD_ACT, CMD_WR, CMD_RDA, CMD_REF } cmd_e;

   localparam int A16_POS = 16;
   localparam int A15_POS = 15;
   localparam int A14_POS = 14;
   localparam int A10_POS = 10;

   typedef struct packed {
      logic        cs_n;
      logic        act_n;
      logic [16:0] a;
   } cmd_bits_t;

   // Fixed opcode bits only; the caller merges in row or column address.
   function automatic cmd_bits_t encode_cmd(input cmd_e cmd);
      cmd_bits_t c;
      c.cs_n  = 1'b0;
      c.act_n = 1'b1;
      c.a     = '0;
      case (cmd)
         CMD_ACT: c.act_n = 1'b0;
         CMD_WR: begin
            c.a[A16_POS] = 1'b1;
            c.a[A15_POS] = 1'b0;
            c.a[A14_POS] = 1'b0;
            c.a[A10_POS] = 1'b0;
         end
         CMD_RDA: begin
            c.a[A16_POS] = 1'b1;
            c.a[A15_POS] = 1'b0;
            c.a[A14_POS] = 1'b1;
            c.a[A10_POS] = 1'b1;
         end
         CMD_REF: c.a[A14_POS] = 1'b1;
         default: c.cs_n = 1'b1;
      endcase
      return c;
   endfunction

   function automatic int max_int(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

   function automatic int sat_sub(input int x, input int y);
      return (x > y) ? x - y : 0;
   endfunction

endpackage

// File: rtl/ddr_timing_counter.sv
// Loadable down-counter that saturates at zero; zero flags an elapsed delay.
module ddr_timing_counter #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             zero
);

   logic [WIDTH-1:0] cnt;

   // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           cnt <= '0;
      else if (load)        cnt <= value;
      else if (cnt != '0)   cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/bank_interleave_sequencer.sv
// Activates a run of banks, bursts writes and/or auto-precharge reads, then optionally refreshes.
module bank_interleave_sequencer
   import bank_interleave_sequencer_pkg::*;
#(
   parameter int BGWIDTH    = 2,
   parameter int BAWIDTH    = 2,
   parameter int ADDRWIDTH  = 17,
   parameter int COLWIDTH   = 10,
   parameter int BL         = 8,
   parameter int T_RCD      = 17,
   parameter int T_RRD_SAME = 6,
   parameter int T_RRD_DIFF = 4,
   parameter int T_RP       = 17,
   parameter int T_RFC      = 34
) (
   input  logic                              ck_t,
   input  logic                              reset_n,
   input  logic                              start,
   input  logic [1:0]                        mode,
   input  logic                              order,
   input  logic                              refresh_en,
   input  logic [BGWIDTH+BAWIDTH-1:0]        nbanks_m1,
   input  logic [ADDRWIDTH-1:0]              row,
   input  logic [COLWIDTH-1:0]               col,
   output logic                              cs_n,
   output logic                              act_n,
   output logic [ADDRWIDTH-1:0]              A,
   output logic [BGWIDTH-1:0]                bg,
   output logic [BAWIDTH-1:0]                ba,
   output logic [2**(BGWIDTH+BAWIDTH)-1:0]   sync,
   output logic                              writing,
   output logic [$clog2(BL)-1:0]             wr_beat,
   output logic                              busy,
   output logic                              done
);

   localparam int NBW   = BGWIDTH + BAWIDTH;
   localparam int BW    = $clog2(BL);
   localparam int T_MAX = max_int(max_int(max_int(T_RCD, T_RRD_SAME), max_int(T_RRD_DIFF, T_RP)), T_RFC);
   localparam int CW    = $clog2(T_MAX + 1);
   // A wait state lasts load+1 cycles, and the command cycle itself eats one more for ACT spacing.
   localparam int LD_SAME = sat_sub(T_RRD_SAME, 2);
   localparam int LD_DIFF = sat_sub(T_RRD_DIFF, 2);
   localparam int LD_RCD  = sat_sub(T_RCD, 2);
   localparam int LD_RP   = sat_sub(T_RP, 1);
   localparam int LD_RFC  = sat_sub(T_RFC, 1);

   state_e                 state;
   logic [NBW-1:0]         k, nb_r;
   logic [BW-1:0]          beat;
   logic [1:0]             mode_r;
   logic                   order_r, ref_r;
   logic [ADDRWIDTH-1:0]   row_r;
   logic [COLWIDTH-1:0]    col_r;

   logic [NBW-1:0]         k_next, issue_k;
   logic                   k_last, beat_last, wtr, do_write;
   logic                   tmr_load, tmr_zero;
   logic [CW-1:0]          tmr_value;
   cmd_e                   issue;
   cmd_bits_t              issue_bits;
   logic [ADDRWIDTH-1:0]   issue_a;
   logic [BGWIDTH-1:0]     issue_bg;
   logic [BAWIDTH-1:0]     issue_ba;

   function automatic logic [BGWIDTH-1:0] bank_bg(input logic [NBW-1:0] idx, input logic ord);
      return ord ? idx[BGWIDTH-1:0] : idx[NBW-1:BAWIDTH];
   endfunction

   function automatic logic [BAWIDTH-1:0] bank_ba(input logic [NBW-1:0] idx, input logic ord);
      return ord ? idx[NBW-1:BGWIDTH] : idx[BAWIDTH-1:0];
   endfunction

   assign k_next    = k + 1'b1;
   assign k_last    = (k == nb_r);
   assign beat_last = (beat == BW'(BL - 1));
   assign wtr       = mode_r[1];
   assign do_write  = (mode_r != 2'b01);

   ddr_timing_counter #(.WIDTH(CW)) u_tmr (
      .clk   (ck_t),
      .rst_n (reset_n),
      .load  (tmr_load),
      .value (tmr_value),
      .zero  (tmr_zero)
   );

   // Command to present next cycle, plus which delay to arm on this edge.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      issue     = CMD_DES;
      issue_k   = k_next;
      tmr_load  = 1'b0;
      tmr_value = '0;
      case (state)
         IDLE:     if (start) begin issue = CMD_ACT; issue_k = '0; end
         ACT: begin
            tmr_load  = 1'b1;
            tmr_value = k_last ? CW'(LD_RCD)
                      : (bank_bg(k_next, order_r) == bank_bg(k, order_r)) ? CW'(LD_SAME) : CW'(LD_DIFF);
         end
         ACT_GAP:  if (tmr_zero) issue = CMD_ACT;
         RCD_WAIT: if (tmr_zero) begin issue = do_write ? CMD_WR : CMD_RDA; issue_k = '0; end
         WRITE: if (beat_last) begin
            if (!k_last)  issue = CMD_WR;
            else if (wtr) begin issue = CMD_RDA; issue_k = '0; end
            else          begin tmr_load = 1'b1; tmr_value = CW'(LD_RP); end
         end
         READ:     if (beat_last && k_last) begin tmr_load = 1'b1; tmr_value = CW'(LD_RP); end
         RD_GAP:   issue = CMD_RDA;
         PRE_WAIT: if (tmr_zero && ref_r) issue = CMD_REF;
         REFRESH:  begin tmr_load = 1'b1; tmr_value = CW'(LD_RFC); end
         default:  ;
      endcase

      issue_bits = encode_cmd(issue);
      issue_a    = ADDRWIDTH'(issue_bits.a);
      issue_bg   = '0;
      issue_ba   = '0;
      case (issue)
         CMD_ACT: begin
            issue_a  = (state == IDLE) ? row : row_r;
            issue_bg = bank_bg(issue_k, order_r);
            issue_ba = bank_ba(issue_k, order_r);
         end
         CMD_WR, CMD_RDA: begin
            issue_a  = issue_a | ADDRWIDTH'(col_r);
            issue_bg = bank_bg(issue_k, order_r);
            issue_ba = bank_ba(issue_k, order_r);
         end
         default: ;
      endcase
   end

   always_ff @(posedge ck_t or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         k       <= '0;
         beat    <= '0;
         nb_r    <= '0;
         mode_r  <= '0;
         order_r <= 1'b0;
         ref_r   <= 1'b0;
         row_r   <= '0;
         col_r   <= '0;
         cs_n    <= 1'b1;
         act_n   <= 1'b1;
         A       <= '0;
         bg      <= '0;
         ba      <= '0;
         sync    <= '0;
         writing <= 1'b0;
         wr_beat <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         cs_n  <= issue_bits.cs_n;
         act_n <= issue_bits.act_n;
         A     <= issue_a;
         bg    <= issue_bg;
         ba    <= issue_ba;
         done  <= 1'b0;
         if (issue == CMD_ACT) sync[{issue_bg, issue_ba}] <= 1'b1;

         if (issue == CMD_WR) begin
            writing <= 1'b1;
            wr_beat <= '0;
         end else if (state == WRITE && !beat_last) begin
            writing <= 1'b1;
            wr_beat <= beat + 1'b1;
         end else begin
            writing <= 1'b0;
            wr_beat <= '0;
         end

         case (state)
            IDLE: if (start) begin
               mode_r  <= mode;
               order_r <= order;
               ref_r   <= refresh_en;
               nb_r    <= nbanks_m1;
               row_r   <= row;
               col_r   <= col;
               k       <= '0;
               busy    <= 1'b1;
               state   <= ACT;
            end
            ACT:      state <= k_last ? RCD_WAIT : ACT_GAP;
            ACT_GAP:  if (tmr_zero) begin k <= k_next; state <= ACT; end
            RCD_WAIT: if (tmr_zero) begin
               k     <= '0;
               beat  <= '0;
               state <= do_write ? WRITE : READ;
            end
            WRITE: if (beat_last) begin
               beat <= '0;
               if (!k_last)  k <= k_next;
               else if (wtr) begin k <= '0; state <= READ; end
               else          state <= PRE_WAIT;
            end else beat <= beat + 1'b1;
            READ: if (beat_last) begin
               beat  <= '0;
               state <= k_last ? PRE_WAIT : RD_GAP;
            end else beat <= beat + 1'b1;
            RD_GAP:   begin k <= k_next; state <= READ; end
            PRE_WAIT: if (tmr_zero) begin
               if (ref_r) state <= REFRESH;
               else begin state <= DONE; done <= 1'b1; sync <= '0; end
            end
            REFRESH:  state <= RFC_WAIT;
            RFC_WAIT: if (tmr_zero) begin state <= DONE; done <= 1'b1; sync <= '0; end
            DONE:     begin state <= IDLE; busy <= 1'b0; end
            default:  state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bank_interleave_sequencer.sv
// Scoreboard bench: a timing model queues expected commands, a negedge monitor compares them.
module tb_bank_interleave_sequencer;

   logic        ck_t = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  mode;
   logic        order;
   logic        refresh_en;
   logic [3:0]  nbanks_m1;
   logic [16:0] row;
   logic [9:0]  col;
   logic        cs_n, act_n;
   logic [16:0] A;
   logic [1:0]  bg, ba;
   logic [15:0] sync;
   logic        writing;
   logic [2:0]  wr_beat;
   logic        busy, done;

   bank_interleave_sequencer dut (
      .ck_t       (ck_t),
      .reset_n    (reset_n),
      .start      (start),
      .mode       (mode),
      .order      (order),
      .refresh_en (refresh_en),
      .nbanks_m1  (nbanks_m1),
      .row        (row),
      .col        (col),
      .cs_n       (cs_n),
      .act_n      (act_n),
      .A          (A),
      .bg         (bg),
      .ba         (ba),
      .sync       (sync),
      .writing    (writing),
      .wr_beat    (wr_beat),
      .busy       (busy),
      .done       (done)
   );

   always #5 ck_t = ~ck_t;

   typedef struct {
      int          cyc;
      logic        cs_n;
      logic        act_n;
      logic        done;
      logic [16:0] a;
      logic [1:0]  bg;
      logic [1:0]  ba;
   } ev_t;

   ev_t  exp_q[$];
   int   act_rel[$];
   int   act_idx[$];
   int   wr_rel[$];
   int   run_base;
   int   run_done_rel;
   bit   run_active;
   bit   mon_on;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   always @(posedge ck_t) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d of run)", tag, got, exp, cyc - run_base);
   endtask

   task automatic push_ev(input int t, input logic csn, input logic actn, input logic dn,
                          input logic [16:0] a, input int g, input int b);
      ev_t e;
      e.cyc = t; e.cs_n = csn; e.act_n = actn; e.done = dn;
      e.a = a; e.bg = 2'(g); e.ba = 2'(b);
      exp_q.push_back(e);
   endtask

   // Timing model built from the command spacing rules, relative to cycle 0.
   task automatic plan(input logic [1:0] md, input logic ord, input int nb, input logic rf,
                       input logic [16:0] rw, input logic [9:0] cl);
      int t;
      int prev_g;
      exp_q.delete(); act_rel.delete(); act_idx.delete(); wr_rel.delete();
      t = 0;
      prev_g = 0;
      for (int k = 0; k <= nb; k++) begin
         int g, b;
         g = ord ? k % 4 : k / 4;
         b = ord ? k / 4 : k % 4;
         if (k > 0) t += (g == prev_g) ? 6 : 4;
         prev_g = g;
         push_ev(t, 1'b0, 1'b0, 1'b0, rw, g, b);
         act_rel.push_back(t);
         act_idx.push_back(g * 4 + b);
      end
      t += 17;
      if (md != 2'b01) begin
         for (int k = 0; k <= nb; k++) begin
            push_ev(t, 1'b0, 1'b1, 1'b0, 17'h10000 | 17'(cl), ord ? k % 4 : k / 4, ord ? k / 4 : k % 4);
            wr_rel.push_back(t);
            t += 8;
         end
      end
      if (md != 2'b00) begin
         for (int k = 0; k <= nb; k++) begin
            push_ev(t, 1'b0, 1'b1, 1'b0, 17'h14400 | 17'(cl), ord ? k % 4 : k / 4, ord ? k / 4 : k % 4);
            t += 8;
            if (k < nb) t += 1;
         end
      end
      t += 17;
      if (rf) begin
         push_ev(t, 1'b0, 1'b1, 1'b0, 17'h04000, 0, 0);
         t += 1 + 34;
      end
      push_ev(t, 1'b1, 1'b1, 1'b1, 17'h0, 0, 0);
      run_done_rel = t;
   endtask

   function automatic void expected_state(input int rel, output logic eb, output logic [15:0] es,
                                          output logic ew, output logic [2:0] ebt);
      eb = 1'b0; es = '0; ew = 1'b0; ebt = '0;
      if (run_active && rel >= 0 && rel <= run_done_rel) begin
         eb = 1'b1;
         if (rel < run_done_rel)
            foreach (act_rel[i]) if (act_rel[i] <= rel) es[act_idx[i]] = 1'b1;
         foreach (wr_rel[i])
            if (rel >= wr_rel[i] && rel < wr_rel[i] + 8) begin
               ew  = 1'b1;
               ebt = 3'(rel - wr_rel[i]);
            end
      end
   endfunction

   always @(negedge ck_t) begin
      if (mon_on) begin
         int          rel;
         logic        eb, ew;
         logic [15:0] es;
         logic [2:0]  ebt;
         ev_t         e;
         rel = cyc - run_base;
         expected_state(rel, eb, es, ew, ebt);
         check("busy", busy, eb);
         check("sync", sync, es);
         check("writing", writing, ew);
         check("wr_beat", wr_beat, ebt);
         if (cs_n) begin
            check("des_a", A, 17'h0);
            check("des_act_n", act_n, 1'b1);
         end
         if (!cs_n || done) begin
            if (exp_q.size() == 0) check("unexpected_event_cycle", rel, -1);
            else begin
               e = exp_q.pop_front();
               check("ev_cycle", rel, e.cyc);
               check("ev_cs_n", cs_n, e.cs_n);
               check("ev_act_n", act_n, e.act_n);
               check("ev_done", done, e.done);
               check("ev_a", A, e.a);
               check("ev_bg", bg, e.bg);
               check("ev_ba", ba, e.ba);
            end
         end
      end
   end

   task automatic wait_cyc(input int target);
      while (cyc < target) begin
         @(posedge ck_t);
         #1;
      end
   endtask

   // Call just after a negedge; inputs are scrambled after sampling to prove they are latched.
   task automatic start_run(input logic [1:0] md, input logic ord, input int nb, input logic rf,
                            input logic [16:0] rw, input logic [9:0] cl);
      plan(md, ord, nb, rf, rw, cl);
      run_base   = cyc + 1;
      run_active = 1'b1;
      mode = md; order = ord; refresh_en = rf; nbanks_m1 = 4'(nb); row = rw; col = cl;
      start = 1'b1;
      @(negedge ck_t);
      start = 1'b0;
      mode = ~md; order = ~ord; refresh_en = ~rf; nbanks_m1 = ~4'(nb); row = ~rw; col = ~cl;
   endtask

   task automatic finish_run();
      wait_cyc(run_base + run_done_rel + 2);
      check("events_left", exp_q.size(), 0);
      @(negedge ck_t);
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_cs_n"}, cs_n, 1'b1);
      check({pfx, "_act_n"}, act_n, 1'b1);
      check({pfx, "_a"}, A, 17'h0);
      check({pfx, "_bg"}, bg, 2'b0);
      check({pfx, "_ba"}, ba, 2'b0);
      check({pfx, "_sync"}, sync, 16'h0);
      check({pfx, "_writing"}, writing, 1'b0);
      check({pfx, "_wr_beat"}, wr_beat, 3'h0);
      check({pfx, "_busy"}, busy, 1'b0);
      check({pfx, "_done"}, done, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; mode = 2'b00; order = 1'b0; refresh_en = 1'b0;
      nbanks_m1 = '0; row = '0; col = '0; mon_on = 1'b0; run_active = 1'b0;
      run_base = 0; run_done_rel = 0;
      repeat (3) @(posedge ck_t);
      #1;
      check_reset_values("rst");
      @(negedge ck_t);
      reset_n = 1'b1;
      mon_on  = 1'b1;
      @(negedge ck_t);

      // Write-then-read over four banks of one group, with refresh.
      start_run(2'b10, 1'b0, 3, 1'b1, 17'h1ABCD, 10'h2A5);
      finish_run();
      // Group-first ordering, write only.
      start_run(2'b00, 1'b1, 3, 1'b1, 17'h00F0F, 10'h155);
      finish_run();
      // Single-bank read, no refresh.
      start_run(2'b01, 1'b0, 0, 1'b0, 17'h12345, 10'h3FF);
      finish_run();
      // All sixteen banks, group crossings every fourth ACT.
      start_run(2'b01, 1'b0, 15, 1'b0, 17'h0AAAA, 10'h001);
      finish_run();
      // Mode 11 behaves as write-then-read.
      start_run(2'b11, 1'b1, 5, 1'b0, 17'h15555, 10'h0C3);
      finish_run();

      // Start while busy must be ignored.
      start_run(2'b10, 1'b0, 3, 1'b1, 17'h1ABCD, 10'h2A5);
      wait_cyc(run_base + 10);
      start = 1'b1; mode = 2'b01; nbanks_m1 = 4'h0; row = 17'h00001; refresh_en = 1'b0;
      @(posedge ck_t);
      #1;
      start = 1'b0;
      finish_run();

      // Asynchronous reset mid-burst, then an immediate restart.
      start_run(2'b10, 1'b0, 3, 1'b1, 17'h1ABCD, 10'h2A5);
      wait_cyc(run_base + 40);
      check("pre_reset_writing", writing, 1'b1);
      #1;
      mon_on  = 1'b0;
      reset_n = 1'b0;
      #1;
      check_reset_values("mid_rst");
      exp_q.delete();
      run_active = 1'b0;
      @(negedge ck_t);
      reset_n = 1'b1;
      mon_on  = 1'b1;
      start_run(2'b10, 1'b0, 3, 1'b1, 17'h1ABCD, 10'h2A5);
      finish_run();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
